// File: rtl/rambyte_word_port.sv
// Word-access initiator for a byte-wide synchronous block RAM.
// Splits each 32-bit word request into four byte accesses and assembles little-endian read data.
module rambyte_word_port #(
    parameter int ADDR_W = 14
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    output logic              READY,
    input  logic              WR,
    input  logic [ADDR_W-3:0] WADDR,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        BE,
    output logic [31:0]       RDATA,
    output logic              ACK,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [7:0]        RAM_DI,
    input  logic [7:0]        RAM_DO
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_k;
    logic              r_wr;
    logic [ADDR_W-3:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_ack;
    logic              r_cap_vld;
    logic [1:0]        r_cap_k;
    logic [31:0]       r_rdata;

    logic w_accept;
    logic w_access;

    assign w_accept = (r_state == S_IDLE) && REQ;
    assign w_access = (r_state == S_ACCESS);

    // Read byte k arrives on RAM_DO one cycle after its address; r_cap_* remembers which lane to fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_k       <= 2'd0;
            r_wr      <= 1'b0;
            r_ack     <= 1'b0;
            r_cap_vld <= 1'b0;
            r_cap_k   <= 2'd0;
            r_rdata   <= 32'd0;
        end else begin
            r_ack     <= 1'b0;
            r_cap_vld <= 1'b0;
            if (r_cap_vld) begin
                r_rdata[{r_cap_k, 3'b000} +: 8] <= RAM_DO;
            end
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_state <= S_ACCESS;
                        r_k     <= 2'd0;
                        r_wr    <= WR;
                    end
                end
                S_ACCESS: begin
                    r_k <= r_k + 2'd1;
                    if (!r_wr) begin
                        r_cap_vld <= 1'b1;
                        r_cap_k   <= r_k;
                    end
                    if (r_k == 2'd3) begin
                        if (r_wr) begin
                            r_state <= S_IDLE;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request payload only needs to be valid while busy, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_waddr <= WADDR;
            r_wdata <= WDATA;
            r_be    <= BE;
        end
    end

    assign READY    = (r_state == S_IDLE);
    assign ACK      = r_ack;
    assign RDATA    = r_rdata;
    assign RAM_EN   = w_access;
    assign RAM_WE   = w_access && r_wr && r_be[r_k];
    assign RAM_ADDR = w_access ? {r_waddr, r_k} : '0;
    assign RAM_DI   = (w_access && r_wr) ? r_wdata[{r_k, 3'b000} +: 8] : 8'd0;

endmodule

// File: doc/rambyte_word_port.md
# rambyte_word_port

Word-access initiator for the byte-wide block RAM. Accepts 32-bit word read/write requests from a processor-side client over a REQ/READY/ACK handshake and sequences them as four byte accesses on the RAM's single synchronous port: EN, WE, 14-bit ADDR, 8-bit DI, 8-bit DO, with one-cycle read latency. Sits between the Minion core data bus and the byte RAM instance, and assembles little-endian words from read data.

## Interface
- ADDR_W, 14, RAM byte-address width; word address width is ADDR_W-2
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  1  request strobe, sampled only while READY=1
- READY  out  1  high when idle and able to accept REQ
- WR  in  1  1 = write, 0 = read; latched at acceptance
- WADDR  in  ADDR_W-2  word address; latched at acceptance
- WDATA  in  32  write data; byte k = WDATA[8k+7:8k]; latched at acceptance
- BE  in  4  write byte enables; ignored for reads
- RDATA  out  32  assembled read data; held until next read completes
- ACK  out  1  one-cycle completion pulse
- RAM_EN  out  1  to RAM EN
- RAM_WE  out  1  to RAM WE
- RAM_ADDR  out  ADDR_W  to RAM ADDR
- RAM_DI  out  8  to RAM DI
- RAM_DO  in  8  from RAM DO, valid the cycle after the address edge

## Operation
- States: IDLE, ACCESS (2-bit byte counter k = 0..3), DRAIN (reads only).
- IDLE: READY=1, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0. When REQ=1 at a rising edge, latch WR/WADDR/WDATA/BE, set k=0, go to ACCESS.
- ACCESS: READY=0, RAM_EN=1, RAM_ADDR={WADDR_latched, k}, RAM_WE=WR & BE[k], RAM_DI=WDATA byte k for writes and 0 for reads. Each edge increments k.
- On the edge leaving k=3: a write returns to IDLE with ACK=1; a read goes to DRAIN.
- DRAIN: RAM_EN=0, RAM_WE=0. On the next edge, capture byte 3, return to IDLE, set ACK=1.
- Read capture: byte k is on RAM_DO in the cycle after the cycle that drove address k. It is registered into RDATA[8k+7:8k] at the end of that cycle. RDATA updates byte-wise during the read; it is final when ACK=1.
- A write never changes RDATA.
- A write always takes four ACCESS cycles, including BE=0000. BE=0000 produces no RAM_WE pulses, but ACK is still returned.
- REQ while READY=0 is ignored and not queued. The requester holds REQ until it sees READY.
- Back-to-back: ACK and READY are both high in the first IDLE cycle, so REQ held high there is accepted at that edge.
- Address arithmetic: the byte index only fills the low 2 bits. There is no carry into WADDR. Word 2^(ADDR_W-2)-1 maps to bytes 0x3FFC..0x3FFF.
- RST asserted at any time, including mid-transaction: immediately go to IDLE, READY=1, ACK=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0, RDATA=0. The aborted request gets no ACK, and RAM contents already written stay as written.

## Timing
- Acceptance edge is E0; E1..E5 are the subsequent edges.
- Write: bytes 0..3 are presented in cycles E0-E1 through E3-E4, and each RAM write happens at E1..E4. ACK=1 and READY=1 in cycle E4-E5. Latency is 4 cycles from acceptance to ACK; throughput is one word per 4 cycles.
- Read: addresses are presented in cycles E0-E1 through E3-E4. Bytes 0..3 are captured at E2..E5. ACK=1 and READY=1 in cycle E5-E6, with RDATA valid from that cycle. Latency is 5 cycles; throughput is one word per 5 cycles.
- ACK is exactly one cycle wide, and is never high while READY=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from REQ to RAM_*.

## Test plan
- Full write: WR=1, WADDR=0x010, WDATA=0xDEADBEEF, BE=1111 -> RAM_ADDR=0x040,0x041,0x042,0x043 with RAM_DI=EF,BE,AD,DE and RAM_WE=1; ACK 4 cycles after acceptance.
- Read-back: WR=0, WADDR=0x010 against a byte-RAM model -> RAM_WE=0 throughout; RDATA=0xDEADBEEF with ACK 5 cycles after acceptance.
- Partial write: BE=0101, WDATA=0x11223344 to 0x010, then read -> RAM_WE high only for bytes 0 and 2; RDATA=0xDE22BE44. A BE=0000 write gives no RAM_WE and still ACKs at 4 cycles.
- Back-to-back: REQ held high across three requests (write, read, write) -> each is accepted in the cycle its predecessor ACKs; no idle gap; REQ pulses during busy are dropped.
- Wrap: read at WADDR=0xFFF -> RAM_ADDR=0x3FFC..0x3FFF; no carry and no access to 0x0000.
- Reset mid-read: assert RST between E2 and E3 -> RAM_EN=0, READY=1, RDATA=0 immediately; no ACK. A fresh read after release returns correct data.
